// File: rtl/ms_dff_stream_monitor.sv
// Serial stream monitor for a flip-flop's Q output: detects an overlapping bit pattern and
// keeps saturating counts of matches, rising transitions and falling transitions.
module ms_dff_stream_monitor #(
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b0101,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Q_in,
  input  logic               Enable,
  input  logic               Clear,
  output logic               Match,
  output logic               Valid,
  output logic [PAT_LEN-1:0] Shift_reg,
  output logic [CNT_W-1:0]   Match_count,
  output logic [CNT_W-1:0]   Rise_count,
  output logic [CNT_W-1:0]   Fall_count
);

  localparam int unsigned      FillW   = $clog2(PAT_LEN + 1);
  localparam logic [FillW-1:0] FillMax = FillW'(PAT_LEN);

  typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

  state_e             state_q, state_d;
  logic [FillW-1:0]   fill_q, fill_d, fill_inc;
  logic [PAT_LEN-1:0] shift_q, shift_d, shift_nxt;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0]   rise_cnt_q, rise_cnt_d;
  logic [CNT_W-1:0]   fall_cnt_q, fall_cnt_d;
  logic               full_nxt, prev_valid;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      fill_q      <= '0;
      shift_q     <= '0;
      match_q     <= 1'b0;
      match_cnt_q <= '0;
      rise_cnt_q  <= '0;
      fall_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      shift_q     <= shift_d;
      match_q     <= match_d;
      match_cnt_q <= match_cnt_d;
      rise_cnt_q  <= rise_cnt_d;
      fall_cnt_q  <= fall_cnt_d;
    end
  end

  // Datapath next-state; shift_q[0] doubles as the previous sample once fill_q is non-zero.
  always_comb begin
    fill_inc    = (fill_q == FillMax) ? fill_q : fill_q + 1'b1;
    shift_nxt   = {shift_q[PAT_LEN-2:0], Q_in};
    full_nxt    = (fill_inc == FillMax);
    prev_valid  = (fill_q != '0);
    fill_d      = fill_q;
    shift_d     = shift_q;
    match_d     = 1'b0;
    match_cnt_d = match_cnt_q;
    rise_cnt_d  = rise_cnt_q;
    fall_cnt_d  = fall_cnt_q;
    if (Clear) begin
      fill_d      = '0;
      shift_d     = '0;
      match_cnt_d = '0;
      rise_cnt_d  = '0;
      fall_cnt_d  = '0;
    end else if (Enable) begin
      fill_d  = fill_inc;
      shift_d = shift_nxt;
      match_d = full_nxt && (shift_nxt == PATTERN);
      if (match_d) match_cnt_d = sat_inc(match_cnt_q);
      if (prev_valid && !shift_q[0] && Q_in) rise_cnt_d = sat_inc(rise_cnt_q);
      if (prev_valid && shift_q[0] && !Q_in) fall_cnt_d = sat_inc(fall_cnt_q);
    end
  end

  always_comb begin
    state_d = state_q;
    if (Clear) begin
      state_d = StIdle;
    end else if (Enable) begin
      unique case (state_q)
        StIdle, StFill: state_d = full_nxt ? StRun : StFill;
        StRun:          state_d = StRun;
        default:        state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    Valid       = (state_q == StRun);
    Match       = match_q;
    Shift_reg   = shift_q;
    Match_count = match_cnt_q;
    Rise_count  = rise_cnt_q;
    Fall_count  = fall_cnt_q;
  end

endmodule

// File: tb/tb_ms_dff_stream_monitor.sv
// Scoreboard bench for ms_dff_stream_monitor: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against two instances (CNT_W=8 and CNT_W=3).
module tb_ms_dff_stream_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, clr = 1'b0, q_drv = 1'b0, use_ff = 1'b0, ff_q = 1'b0;
  logic       q_in;
  logic       m8, v8, m3, v3;
  logic [3:0] sr8, sr3;
  logic [7:0] mc8, rc8, fc8;
  logic [2:0] mc3, rc3, fc3;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { string name; logic [29:0] val; } exp8_t;
  typedef struct { string name; logic [8:0]  val; } exp3_t;
  exp8_t q8[$];
  exp3_t q3[$];
  exp8_t e8c;
  exp3_t e3c;
  logic [29:0] got8;
  logic [8:0]  got3;

  always #5 clk = ~clk;

  // Simple flip-flop stage standing in for the master-slave DFF feeding the monitor.
  always @(posedge clk) ff_q <= q_drv;
  assign q_in = use_ff ? ff_q : q_drv;

  ms_dff_stream_monitor #(.PAT_LEN(4), .PATTERN(4'b0101), .CNT_W(8)) dut8 (
    .Clock(clk), .Reset_n(rst_n), .Q_in(q_in), .Enable(en), .Clear(clr),
    .Match(m8), .Valid(v8), .Shift_reg(sr8),
    .Match_count(mc8), .Rise_count(rc8), .Fall_count(fc8)
  );

  ms_dff_stream_monitor #(.PAT_LEN(4), .PATTERN(4'b0101), .CNT_W(3)) dut3 (
    .Clock(clk), .Reset_n(rst_n), .Q_in(q_in), .Enable(en), .Clear(clr),
    .Match(m3), .Valid(v3), .Shift_reg(sr3),
    .Match_count(mc3), .Rise_count(rc3), .Fall_count(fc3)
  );

  always @(negedge clk) begin
    while (q8.size() > 0) begin
      e8c  = q8.pop_front();
      got8 = {m8, v8, sr8, mc8, rc8, fc8};
      n_tests++;
      if (got8 !== e8c.val) begin
        n_fail++;
        $display("FAIL %s: got m=%b v=%b sr=%b mc=%0d rc=%0d fc=%0d, required m=%b v=%b sr=%b mc=%0d rc=%0d fc=%0d",
                 e8c.name, got8[29], got8[28], got8[27:24], got8[23:16], got8[15:8], got8[7:0],
                 e8c.val[29], e8c.val[28], e8c.val[27:24], e8c.val[23:16], e8c.val[15:8],
                 e8c.val[7:0]);
      end
    end
    while (q3.size() > 0) begin
      e3c  = q3.pop_front();
      got3 = {mc3, rc3, fc3};
      n_tests++;
      if (got3 !== e3c.val) begin
        n_fail++;
        $display("FAIL %s: got mc=%0d rc=%0d fc=%0d, required mc=%0d rc=%0d fc=%0d",
                 e3c.name, got3[8:6], got3[5:3], got3[2:0],
                 e3c.val[8:6], e3c.val[5:3], e3c.val[2:0]);
      end
    end
  end

  task automatic e8(input string nm, input logic m, input logic v, input logic [3:0] sr,
                    input int mc, input int rc, input int fc);
    exp8_t e;
    e.name = nm;
    e.val  = {m, v, sr, 8'(mc), 8'(rc), 8'(fc)};
    q8.push_back(e);
  endtask

  task automatic e3(input string nm, input int mc, input int rc, input int fc);
    exp3_t e;
    e.name = nm;
    e.val  = {3'(mc), 3'(rc), 3'(fc)};
    q3.push_back(e);
  endtask

  // Drive one edge; expectations are pushed #1 after the edge by the caller.
  task automatic cyc(input logic e, input logic c, input logic q);
    @(negedge clk);
    en = e; clr = c; q_drv = q;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst(input string nm);
    @(posedge clk);
    #2 rst_n = 1'b0; en = 1'b0; clr = 1'b0;
    #1;
    e8(nm, 0, 0, 4'b0000, 0, 0, 0);
    e3(nm, 0, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #10000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    pulse_rst("reset");

    // 1: 0,1,0,1,0,1 -> matches after samples 4 and 6
    cyc(1, 0, 0); e8("t1 s1", 0, 0, 4'b0000, 0, 0, 0);
    cyc(1, 0, 1); e8("t1 s2", 0, 0, 4'b0001, 0, 1, 0);
    cyc(1, 0, 0); e8("t1 s3", 0, 0, 4'b0010, 0, 1, 1);
    cyc(1, 0, 1); e8("t1 s4", 1, 1, 4'b0101, 1, 2, 1);
    cyc(1, 0, 0); e8("t1 s5", 0, 1, 4'b1010, 1, 2, 2);
    cyc(1, 0, 1); e8("t1 s6", 1, 1, 4'b0101, 2, 3, 2);
    cyc(0, 0, 0); e8("t1 idle", 0, 1, 4'b0101, 2, 3, 2);

    // 2: 1,0,1, five disabled cycles, then 0,1
    pulse_rst("t2 reset");
    cyc(1, 0, 1); e8("t2 s1", 0, 0, 4'b0001, 0, 0, 0);
    cyc(1, 0, 0); e8("t2 s2", 0, 0, 4'b0010, 0, 0, 1);
    cyc(1, 0, 1); e8("t2 s3", 0, 0, 4'b0101, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, i[0]); e8("t2 gap", 0, 0, 4'b0101, 0, 1, 1);
    end
    cyc(1, 0, 0); e8("t2 s4", 0, 1, 4'b1010, 0, 1, 2);
    cyc(1, 0, 1); e8("t2 s5", 1, 1, 4'b0101, 1, 2, 2);

    // 3: 20 alternating samples; CNT_W=3 counters saturate at 7
    pulse_rst("t3 reset");
    for (int i = 1; i <= 20; i++) begin
      cyc(1, 0, (i % 2 == 0));
      if (i == 12) e3("t3 n12", 5, 6, 5);
      if (i == 14) e3("t3 n14", 6, 7, 6);
      if (i == 20) e3("t3 n20", 7, 7, 7);
    end
    e8("t3 wide", 1, 1, 4'b0101, 9, 10, 9);

    // 4: async reset after 0,1,0 then refill
    pulse_rst("t4 reset");
    cyc(1, 0, 0); e8("t4 s1", 0, 0, 4'b0000, 0, 0, 0);
    cyc(1, 0, 1); e8("t4 s2", 0, 0, 4'b0001, 0, 1, 0);
    cyc(1, 0, 0); e8("t4 s3", 0, 0, 4'b0010, 0, 1, 1);
    pulse_rst("t4 midreset");
    cyc(1, 0, 1); e8("t4 r1", 0, 0, 4'b0001, 0, 0, 0);
    cyc(1, 0, 0); e8("t4 r2", 0, 0, 4'b0010, 0, 0, 1);
    cyc(1, 0, 1); e8("t4 r3", 0, 0, 4'b0101, 0, 1, 1);
    cyc(1, 0, 0); e8("t4 r4", 0, 1, 4'b1010, 0, 1, 2);
    cyc(1, 0, 1); e8("t4 r5", 1, 1, 4'b0101, 1, 2, 2);
    cyc(1, 0, 0); e8("t4 r6", 0, 1, 4'b1010, 1, 2, 3);
    cyc(1, 0, 1); e8("t4 r7", 1, 1, 4'b0101, 2, 3, 3);

    // 5: Clear with Enable and Q_in=1 discards the sample; next sample is not an edge
    cyc(1, 1, 1); e8("t5 clear run", 0, 0, 4'b0000, 0, 0, 0);
    cyc(1, 0, 1); e8("t5 s1", 0, 0, 4'b0001, 0, 0, 0);
    cyc(1, 0, 0); e8("t5 s2", 0, 0, 4'b0010, 0, 0, 1);
    cyc(1, 1, 1); e8("t5 clear fill", 0, 0, 4'b0000, 0, 0, 0);
    cyc(1, 0, 1); e8("t5 s3", 0, 0, 4'b0001, 0, 0, 0);

    // 6: Q_in from the flip-flop stage, D toggling 1,0,1,0,1,0 -> Q lags one edge
    cyc(0, 0, 0);
    pulse_rst("t6 reset");
    use_ff = 1'b1;
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    cyc(1, 0, 1);
    cyc(1, 0, 0); e8("t6 e4", 1, 1, 4'b0101, 1, 2, 1);
    cyc(1, 0, 1);
    cyc(1, 0, 0); e8("t6 e6", 1, 1, 4'b0101, 2, 3, 2);
    cyc(0, 0, 0); e8("t6 hold", 0, 1, 4'b0101, 2, 3, 2);

    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (q8.size() != 0 || q3.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending, required 0/0", q8.size(), q3.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
